// File: rtl/dcim_shift_accumulator_if.sv
// Beat-in / result-out handshake bundle for dcim_shift_accumulator.
// The master side is whatever feeds the adder-tree beats and consumes the results.
interface dcim_shift_accumulator_if #(
    parameter int IN_W  = 27,
    parameter int OUT_W = 51,
    parameter int NCH   = 4
);
    logic                 st;
    logic                 in_valid;
    logic                 in_ready;
    logic [NCH*IN_W-1:0]  in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [NCH*OUT_W-1:0] out_data;
    logic                 busy;

    modport master (
        output st, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  st, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/dcim_shift_accumulator.sv
// Multi-channel bit-serial shift-accumulator with a one-deep valid/ready result register.
// Define DCIM_SACC_SIGNED_EN to subtract beat 0 (MSB plane) for two's-complement activations.
module dcim_shift_accumulator #(
    parameter int IN_W  = 27,
    parameter int OUT_W = 51,
    parameter int NCH   = 4,
    parameter int NBITS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    dcim_shift_accumulator_if.slave  bus
);
    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;

    logic [CW-1:0] cnt_reg;
    logic          out_valid_reg;
    logic          last_beat;
    logic          accept;

    assign last_beat    = (cnt_reg == CW'(NBITS - 1));
    // Only the final beat needs the output slot; earlier beats never stall.
    assign bus.in_ready = !(last_beat && out_valid_reg && !bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready && !bus.st;
    assign bus.busy     = (cnt_reg != '0);
    assign bus.out_valid = out_valid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (bus.st) begin
            cnt_reg <= '0;
        end else if (accept) begin
            cnt_reg <= last_beat ? '0 : cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
        end else if (accept && last_beat) begin
            out_valid_reg <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [OUT_W-1:0] acc_reg;
            logic [OUT_W-1:0] res_reg;
            logic [OUT_W-1:0] acc_next;
            logic [OUT_W-1:0] shifted;
            logic [OUT_W-1:0] partial;

            assign partial = {{(OUT_W-IN_W){bus.in_data[gi*IN_W+IN_W-1]}},
                              bus.in_data[gi*IN_W +: IN_W]};
            assign shifted = acc_reg << 1;
`ifdef DCIM_SACC_SIGNED_EN
            assign acc_next = (cnt_reg == '0) ? shifted - partial : shifted + partial;
`else
            assign acc_next = shifted + partial;
`endif

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc_reg <= '0;
                end else if (bus.st) begin
                    acc_reg <= '0;
                end else if (accept) begin
                    acc_reg <= last_beat ? '0 : acc_next;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    res_reg <= '0;
                end else if (accept && last_beat) begin
                    res_reg <= acc_next;
                end
            end

            assign bus.out_data[gi*OUT_W +: OUT_W] = res_reg;
        end
    endgenerate
endmodule

// File: tb/tb_dcim_shift_accumulator.sv
// Self-checking bench: table-driven passes with a result scoreboard, plus reset,
// back-pressure, abort and wrap-around sequences.
module tb_dcim_shift_accumulator;
    localparam int IN_W  = 27;
    localparam int OUT_W = 51;
    localparam int NCH   = 2;
    localparam int NB    = 4;
    localparam int WO_W  = 31;

    typedef struct packed {
        logic [3:0][31:0] b0;
        logic [3:0][31:0] b1;
        longint           eu0;
        longint           eu1;
        longint           es0;
        longint           es1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcim_shift_accumulator_if #(.IN_W(IN_W), .OUT_W(OUT_W), .NCH(NCH)) bus ();
    dcim_shift_accumulator_if #(.IN_W(IN_W), .OUT_W(WO_W), .NCH(1)) wbus ();

    dcim_shift_accumulator #(.IN_W(IN_W), .OUT_W(OUT_W), .NCH(NCH), .NBITS(NB)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    dcim_shift_accumulator #(.IN_W(IN_W), .OUT_W(WO_W), .NCH(1), .NBITS(NB)) dut_w (
        .clk(clk), .rst(rst), .bus(wbus)
    );

    int checks = 0;
    int errors = 0;
    int stalls = 0;
    logic [NCH*OUT_W-1:0] sb[$];
    logic [NCH*OUT_W-1:0] last_exp = '0;
    vec_t tab[5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input int a0, a1, a2, a3, c0, c1, c2, c3,
                                input longint u0, u1, s0, s1);
        vec_t v;
        v.b0 = {a3, a2, a1, a0};
        v.b1 = {c3, c2, c1, c0};
        v.eu0 = u0; v.eu1 = u1; v.es0 = s0; v.es1 = s1;
        return v;
    endfunction

    function automatic logic [NCH*OUT_W-1:0] pack_exp(input longint e0, e1s, u0, u1);
`ifdef DCIM_SACC_SIGNED_EN
        return {OUT_W'(e1s), OUT_W'(e0)};
`else
        return {OUT_W'(u1), OUT_W'(u0)};
`endif
    endfunction

    function automatic logic [NCH*OUT_W-1:0] vexp(input vec_t v);
        return pack_exp(v.es0, v.es1, v.eu0, v.eu1);
    endfunction

    // Drive one beat, wait (bounded) until accepted; push expectation on the final beat.
    task automatic send(input int d0, input int d1, input bit last,
                        input logic [NCH*OUT_W-1:0] e);
        bit ok = 1'b0;
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = {IN_W'(d1), IN_W'(d0)};
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stuck 0 for %0d cycles, required 1", n);
        end
        stalls += n - 1;
        if (last) begin
            sb.push_back(e);
            last_exp = e;
        end
    endtask

    task automatic run_vec(input vec_t v);
        for (int k = 0; k < NB; k++)
            send(int'(v.b0[k]), int'(v.b1[k]), k == NB - 1, vexp(v));
    endtask

    task automatic drain(input string name);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk({name, "_sb_empty"}, 128'(sb.size()), 128'd0);
        chk({name, "_valid_idle"}, 128'(bus.out_valid), 128'd0);
    endtask

    // Scoreboard consumer: a result transfers at the next edge when valid && ready.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result: got %0h with no result pending", bus.out_data);
            end else begin
                logic [NCH*OUT_W-1:0] e;
                e = sb.pop_front();
                chk("result", 128'(bus.out_data), 128'(e));
                $display("result %0h expected %0h", bus.out_data, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0] = mk(10, 20, 30, 0, 1, 1, 1, 1, 220, 15, 60, -1);
        tab[1] = mk(1, 0, 0, 0, 0, 0, 0, 5, 8, 5, -8, 5);
        tab[2] = mk(-1, 0, 0, 0, 3, -2, 7, 100, -8, 130, 8, 82);
        tab[3] = mk(67108863, 67108863, 67108863, 67108863,
                    -67108864, -67108864, -67108864, -67108864,
                    1006632945, -1006632960, -67108863, 67108864);
        tab[4] = mk(0, 0, 0, 0, 123, 456, 789, 1000, 0, 5386, 0, 3418);

        bus.st = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        wbus.st = 1'b0; wbus.in_valid = 1'b0; wbus.in_data = '0; wbus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_out_data", 128'(bus.out_data), 128'd0);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        @(posedge clk); #1;

        // Back-to-back table passes with out_ready high: no stalls allowed.
        for (int v = 0; v < 5; v++) run_vec(tab[v]);
        chk("no_bubbles_stalls", 128'(stalls), 128'd0);
        drain("table");

        // Asynchronous reset mid-pass.
        @(posedge clk); #1;
        send(7, 7, 1'b0, '0);
        send(7, 7, 1'b0, '0);
        bus.in_valid = 1'b0;
        chk("mid_busy", 128'(bus.busy), 128'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("arst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("arst_out_data", 128'(bus.out_data), 128'd0);
        chk("arst_busy", 128'(bus.busy), 128'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        run_vec(tab[0]);
        drain("post_rst");

        // Back-pressure: second pass's final beat must stall until out_ready.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        run_vec(tab[1]);
        for (int k = 0; k < NB - 1; k++) send(int'(tab[2].b0[k]), int'(tab[2].b1[k]), 1'b0, '0);
        chk("bp_nonfinal_stalls", 128'(stalls), 128'd0);
        bus.in_data = {IN_W'(int'(tab[2].b1[NB-1])), IN_W'(int'(tab[2].b0[NB-1]))};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_in_ready_low", 128'(bus.in_ready), 128'd0);
            chk("bp_held_valid", 128'(bus.out_valid), 128'd1);
            chk("bp_held_data", 128'(bus.out_data), 128'(vexp(tab[1])));
            @(posedge clk);
        end
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 128'(bus.in_ready), 128'd1);
        @(posedge clk); #1;
        sb.push_back(vexp(tab[2]));
        last_exp = vexp(tab[2]);
        drain("backpressure");

        // Abort: st discards the coinciding beat and leaves the result register alone.
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) send(int'(tab[3].b0[k]), int'(tab[3].b1[k]), 1'b0, '0);
        bus.st = 1'b1;
        bus.in_data = {IN_W'(999), IN_W'(999)};
        @(posedge clk); #1;
        bus.st = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("st_busy", 128'(bus.busy), 128'd0);
        chk("st_out_valid", 128'(bus.out_valid), 128'd0);
        chk("st_out_data_kept", 128'(bus.out_data), 128'(last_exp));
        @(posedge clk); #1;
        send(5, 0, 1'b0, '0);
        send(0, 0, 1'b0, '0);
        send(0, 0, 1'b0, '0);
        send(0, 1, 1'b1, pack_exp(-40, 1, 40, 1));
        drain("abort");

        // Narrow instance: arithmetic wraps modulo 2^31 without saturation.
        @(posedge clk); #1;
        wbus.in_valid = 1'b1;
        wbus.in_data  = 27'h3FFFFFF;
        repeat (NB) @(posedge clk);
        #1 wbus.in_valid = 1'b0;
        @(negedge clk);
        chk("wrap_valid", 128'(wbus.out_valid), 128'd1);
`ifdef DCIM_SACC_SIGNED_EN
        chk("wrap_data", 128'(wbus.out_data), 128'h7C000001);
`else
        chk("wrap_data", 128'(wbus.out_data), 128'h3BFFFFF1);
`endif

        @(negedge clk);
        chk("final_sb_empty", 128'(sb.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
